pipe_rr_sched: RTL
==================

Name: pipe_rr_sched

Overview:
- Shares one 3-stage arithmetic datapath, F = ((A+B) + (C-D)) * D, between two requesters.
- Round-robin arbiter with a valid/ready handshake on each request port.
- A tag pipeline tracks which requester owns each in-flight operation.
- A per-requester outstanding-credit limit prevents either requester from flooding the pipe.
- Sits between two producer blocks and the shared arithmetic unit; results leave on one shared result bus tagged with requester ID.

Parameters:
- N, 10, operand and result width in bits.
- LAT, 3, datapath latency in clock edges; fixed, not user-tunable.
- MAX_OUT, 2, maximum in-flight operations per requester (1..LAT).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a, req0_b, req0_c, req0_d  in  N each  requester 0 operands.
- req1_valid  in  1  requester 1 has operands.
- req1_ready  out  1  requester 1 operands accepted this cycle.
- req1_a, req1_b, req1_c, req1_d  in  N each  requester 1 operands.
- res_valid  out  1  result valid; one-cycle pulse per operation.
- res_id  out  1  owning requester of res_data.
- res_data  out  N  result F.
- idle  out  1  no operations in flight, both outstanding counts zero.

Behaviour:
- **Clock and reset:** one clock, clk, rising edge. Reset is synchronous, active-high, on rst.
- **Reset values:**
  - res_valid=0, res_id=0, res_data=0, idle=1.
  - RR pointer=0, both outstanding counters=0, all tag-pipe valid bits=0.
- **Handshake:**
  - A transfer occurs on a rising edge where reqX_valid && reqX_ready.
  - Once asserted, valid must hold with stable operands until the transfer.
  - reqX_ready is combinational from the valids, the RR pointer and the counters.
  - Valid must not depend on ready.
- **Eligibility:** requester X is eligible when reqX_valid && outX < MAX_OUT && !rst.
- **Grant:**
  - At most one ready per cycle.
  - If one requester is eligible, it is granted.
  - If both are eligible, the requester equal to the RR pointer is granted.
  - On a grant, the pointer moves to the non-granted requester. With no grant, the pointer holds.
- **Latency:**
  - Operands accepted at edge t give res_valid=1 with that result during the cycle after edge t+LAT.
  - Back-to-back accepts give back-to-back results, in order, and results are never reordered.
- **Datapath:**
  - Stage 1 registers A+B, C-D and D.
  - Stage 2 registers the sum of the stage-1 values, plus D.
  - Stage 3 registers the product.
  - All arithmetic is unsigned modulo 2^N: the subtraction wraps, and the product keeps its low N bits.
  - A valid bit and ID bit travel alongside each stage.
- **Result bus:**
  - Has no backpressure; the consumer must always accept.
  - res_data and res_id hold their last value while res_valid=0.
- **Counters:**
  - outX increments on an accept from X.
  - outX decrements on a res_valid with res_id=X.
  - A simultaneous increment and decrement leaves the counter unchanged.
  - A counter never exceeds MAX_OUT and never underflows; an underflow is an assertion error in the bench.
- **idle:** registered; 1 when both counters are 0 and no tag-pipe valid bit is set.
- **Reset mid-operation:**
  - All in-flight operations are dropped, and no res_valid follows for them.
  - Ready is 0 during the reset cycle.
  - Counters and pointer clear.
- **Both requesters saturated:** ready stays 0 until a result for that requester retires; credit frees on the same edge the result appears.

Decomposition:
- Package pipe_sched_pkg holds:
  - LAT=3.
  - ID_W=1.
  - ID_REQ0=1'b0 and ID_REQ1=1'b1.
  - The outstanding-counter width, $clog2(MAX_OUT+1).
- One sub-module, pipe_core: the 3-stage datapath with valid/ID sideband (in_valid, in_id, a, b, c, d → out_valid, out_id, f) and synchronous clear on rst.
- Arbiter, pointer and counters stay in pipe_rr_sched.

Test Plan:
1. Req0 only, A=10 B=12 C=6 D=3 at edge t → res_valid in cycle after t+3, res_id=0, res_data=75; idle returns to 1 one cycle later.
2. Both valid at the same time after reset: req0 {5,3,4,2}, req1 {15,10,6,3} → req0 granted first (pointer=0), req1 next cycle; results 20 (id 0) then 84 (id 1) on consecutive cycles.
3. Req1 valid every cycle with MAX_OUT=2 → accepts on 2 consecutive edges, then ready=0 for 2 cycles, then ready again on the edge its first result retires; sustained rate is 2 ops per 4 cycles.
4. Wrap: A=1000 B=1000 C=1 D=1 → res_data=976. A=0 B=0 C=0 D=1 → (0+1023)*1 = 1023.
5. Assert rst for 1 cycle while 3 operations are in flight → no res_valid afterwards, counters 0, idle=1, and the next req1-only accept gets ready immediately.
6. Both valid continuously for 8 cycles → grants strictly alternate 0,1,0,1,…, subject to credits; no requester is starved; res_id sequence matches the grant order.

Source files
------------

// File: rtl/pipe_sched_pkg.sv
// pipe_sched_pkg: shared constants for the round-robin pipelined scheduler
package pipe_sched_pkg;
    localparam int LAT = 3;
    localparam int ID_W = 1;
    localparam logic [ID_W-1:0] ID_REQ0 = 1'b0;
    localparam logic [ID_W-1:0] ID_REQ1 = 1'b1;
    localparam int MAX_OUT_DEF = 2;
    localparam int CNT_W = $clog2(MAX_OUT_DEF + 1);
endpackage

// File: rtl/pipe_rr_sched_if.sv
// pipe_rr_sched_if: two request handshakes plus the shared tagged result bus
interface pipe_rr_sched_if
    import pipe_sched_pkg::*;
#(
    parameter int N = 10
);
    logic            req0_valid, req0_ready;
    logic [N-1:0]    req0_a, req0_b, req0_c, req0_d;
    logic            req1_valid, req1_ready;
    logic [N-1:0]    req1_a, req1_b, req1_c, req1_d;
    logic            res_valid;
    logic [ID_W-1:0] res_id;
    logic [N-1:0]    res_data;
    modport master (
        output req0_valid, req0_a, req0_b, req0_c, req0_d,
        output req1_valid, req1_a, req1_b, req1_c, req1_d,
        input  req0_ready, req1_ready, res_valid, res_id, res_data
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_c, req0_d,
        input  req1_valid, req1_a, req1_b, req1_c, req1_d,
        output req0_ready, req1_ready, res_valid, res_id, res_data
    );
endinterface

// File: rtl/pipe_core.sv
// pipe_core: 3-stage ((A+B)+(C-D))*D datapath with valid/ID sideband
module pipe_core
    import pipe_sched_pkg::*;
#(
    parameter int N = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [ID_W-1:0] i_id,
    input  logic [N-1:0]    i_a,
    input  logic [N-1:0]    i_b,
    input  logic [N-1:0]    i_c,
    input  logic [N-1:0]    i_d,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id,
    output logic [N-1:0]    o_f,
    output logic            o_busy
);
    logic [LAT-1:0]           r_v;
    logic [LAT-1:0][ID_W-1:0] r_id;
    logic [N-1:0]             r_ab, r_cd, r_d1, r_sum, r_d2, r_f;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_id  <= '0;
            r_ab  <= '0;
            r_cd  <= '0;
            r_d1  <= '0;
            r_sum <= '0;
            r_d2  <= '0;
            r_f   <= '0;
        end else begin
            r_v   <= {r_v[LAT-2:0], i_valid};
            r_id  <= {r_id[LAT-2:0], i_id};
            r_ab  <= i_a + i_b;
            r_cd  <= i_c - i_d;
            r_d1  <= i_d;
            r_sum <= r_ab + r_cd;
            r_d2  <= r_d1;
            r_f   <= r_sum * r_d2;
        end
    end
    assign o_valid = r_v[LAT-1];
    assign o_id    = r_id[LAT-1];
    assign o_f     = r_f;
    assign o_busy  = |r_v;
endmodule

// File: rtl/pipe_rr_sched.sv
// pipe_rr_sched: round-robin, credit-limited sharing of pipe_core between two requesters
module pipe_rr_sched
    import pipe_sched_pkg::*;
#(
    parameter int N = 10,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pipe_rr_sched_if.slave bus,
    output logic           o_idle
);
    logic [CNT_W-1:0] r_out0, r_out1;
    logic [ID_W-1:0]  r_ptr, r_res_id;
    logic             r_res_valid, r_idle;
    logic [N-1:0]     r_res_data;
    logic             w_elig0, w_elig1, w_gnt0, w_gnt1, w_ret0, w_ret1;
    logic [ID_W-1:0]  w_in_id;
    logic [N-1:0]     w_a, w_b, w_c, w_d;
    logic             w_valid, w_busy;
    logic [ID_W-1:0]  w_id;
    logic [N-1:0]     w_f;
    always_comb begin
        w_elig0 = bus.req0_valid && (r_out0 < CNT_W'(MAX_OUT)) && !rst;
        w_elig1 = bus.req1_valid && (r_out1 < CNT_W'(MAX_OUT)) && !rst;
        w_gnt0  = w_elig0 && (!w_elig1 || r_ptr == ID_REQ0);
        w_gnt1  = w_elig1 && (!w_elig0 || r_ptr == ID_REQ1);
        w_in_id = w_gnt1 ? ID_REQ1 : ID_REQ0;
        w_a     = w_gnt1 ? bus.req1_a : bus.req0_a;
        w_b     = w_gnt1 ? bus.req1_b : bus.req0_b;
        w_c     = w_gnt1 ? bus.req1_c : bus.req0_c;
        w_d     = w_gnt1 ? bus.req1_d : bus.req0_d;
        // credit returns as the result enters the output register, so it frees on the edge the result appears
        w_ret0  = w_valid && w_id == ID_REQ0;
        w_ret1  = w_valid && w_id == ID_REQ1;
    end
    pipe_core #(.N(N)) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_gnt0 || w_gnt1),
        .i_id    (w_in_id),
        .i_a     (w_a),
        .i_b     (w_b),
        .i_c     (w_c),
        .i_d     (w_d),
        .o_valid (w_valid),
        .o_id    (w_id),
        .o_f     (w_f),
        .o_busy  (w_busy)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= ID_REQ0;
            r_out0      <= '0;
            r_out1      <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= ID_REQ0;
            r_res_data  <= '0;
            r_idle      <= 1'b1;
        end else begin
            r_ptr       <= w_gnt0 ? ID_REQ1 : w_gnt1 ? ID_REQ0 : r_ptr;
            r_out0      <= r_out0 + CNT_W'(w_gnt0) - CNT_W'(w_ret0);
            r_out1      <= r_out1 + CNT_W'(w_gnt1) - CNT_W'(w_ret1);
            r_res_valid <= w_valid;
            if (w_valid) begin
                r_res_id   <= w_id;
                r_res_data <= w_f;
            end
            r_idle      <= r_out0 == '0 && r_out1 == '0 && !w_busy && !(w_gnt0 || w_gnt1);
        end
    end
    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_id     = r_res_id;
    assign bus.res_data   = r_res_data;
    assign o_idle         = r_idle;
endmodule
